// File: rtl/mac8_pkg.sv
// Shared types and default sizing for the MAC8 operand feeder.
package mac8_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N          = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    typedef logic [DEF_DATA_WIDTH-1:0] operand_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: dout presents the head entry combinationally, 0 when empty.
module sync_fifo_sa #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A pop on the same cycle as a push wins; the push is discarded.
    assign do_push = push && !full && !do_pop;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                count_reg  <= count_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                count_reg  <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac8_feeder.sv
// Operand sequencer for the 8-lane systolic MAC array: buffers A lanes and the B vector,
// then issues clear, streams B into stage 0 and pops A lanes on the array's pipelined enables.
module mac8_feeder
    import mac8_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N,
    parameter int SEL_W      = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  En_in,
    output logic                  Clr_in,
    output logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_in [0:N-1],
    input  logic [N-1:0]          en_out
);

    localparam int CNT_W = $clog2(N + 1);

    feeder_state_t         state_reg;
    logic [CNT_W-1:0]      issued_reg;

    logic [N-1:0]          lane_full;
    logic [N-1:0]          lane_empty;
    logic [N-1:0]          lane_at_n;
    logic [CNT_W-1:0]      lane_count [0:N-1];
    logic                  b_full;
    logic                  b_empty;
    logic [CNT_W-1:0]      b_count;
    logic [DATA_WIDTH-1:0] b_head;
    logic                  b_pop;

    logic                  wr_ok;
    logic [N:0]            wr_drop;
    logic                  wr_err;
    logic                  pop_err;

    assign busy    = (state_reg != IDLE);
    assign ready   = (state_reg == IDLE) && (&lane_at_n) && (b_count == CNT_W'(N));
    assign wr_ok   = wr_en && (state_reg == IDLE);
    assign b_pop   = !b_empty && ((state_reg == CLR) ||
                     ((state_reg == STREAM) && (issued_reg != CNT_W'(N))));
    assign wr_err  = wr_en && (busy || (wr_sel > SEL_W'(N)) || (|wr_drop));
    assign pop_err = |(en_out & lane_empty);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : gen_lane
            assign lane_at_n[gi] = (lane_count[gi] == CNT_W'(N));
            assign wr_drop[gi]   = (wr_sel == SEL_W'(gi)) && (lane_full[gi] || en_out[gi]);

            sync_fifo_sa #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (N)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (wr_ok && (wr_sel == SEL_W'(gi))),
                .pop   (en_out[gi]),
                .din   (wr_data),
                .dout  (a_in[gi]),
                .full  (lane_full[gi]),
                .empty (lane_empty[gi]),
                .count (lane_count[gi])
            );
        end
    endgenerate

    assign wr_drop[N] = (wr_sel == SEL_W'(N)) && (b_full || b_pop);

    sync_fifo_sa #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (N)
    ) u_b_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_ok && (wr_sel == SEL_W'(N))),
        .pop   (b_pop),
        .din   (wr_data),
        .dout  (b_head),
        .full  (b_full),
        .empty (b_empty),
        .count (b_count)
    );

    // Outputs are registered on the edge that enters each state, so En_in/Clr_in/done
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            issued_reg <= '0;
            En_in      <= 1'b0;
            Clr_in     <= 1'b0;
            b_in       <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (wr_err || pop_err) begin
                err <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start && ready) begin
                        state_reg <= CLR;
                        Clr_in    <= 1'b1;
                    end
                end
                CLR: begin
                    state_reg  <= STREAM;
                    Clr_in     <= 1'b0;
                    En_in      <= 1'b1;
                    b_in       <= b_head;
                    issued_reg <= CNT_W'(1);
                end
                STREAM: begin
                    if (issued_reg == CNT_W'(N)) begin
                        state_reg <= DRAIN;
                        En_in     <= 1'b0;
                    end else begin
                        b_in       <= b_head;
                        issued_reg <= issued_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (en_out == '0) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac8_feeder.md
Name: mac8_feeder

Overview:
- Upstream operand sequencer for the 8-lane systolic MAC array.
- Buffers one N×N A matrix (one FIFO per lane) and one N-element B vector.
- On start, issues a one-cycle clear, then streams B with enable into array stage 0.
- Pops each lane's A FIFO using the array's pipelined enables, so a_in[i] is always aligned with the B value arriving at lane i; reports done once the pipeline has drained and all c_out values are final.

Parameters:
- DATA_WIDTH, 8, operand width for A and B.
- N, 8, number of lanes; also the depth of each FIFO and the B vector length.
- SEL_W, $clog2(N+1), width of the write-select field.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  load strobe.
- wr_sel  input  SEL_W  target FIFO: 0..N-1 selects A lane FIFO; N selects B FIFO; values above N are illegal.
- wr_data  input  DATA_WIDTH  load data.
- start  input  1  begin computation (level sampled each cycle).
- ready  output  1  every FIFO holds exactly N entries and FSM is IDLE.
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle pulse when results are final.
- err  output  1  sticky error flag; cleared only by reset.
- En_in  output  1  enable into array stage 0.
- Clr_in  output  1  clear into array stage 0.
- b_in  output  DATA_WIDTH  B operand into stage 0.
- a_in  output  DATA_WIDTH × [0:N-1]  per-lane A operand.
- en_out  input  N  array's pipelined enables; en_out[i] pops A FIFO i.

Behaviour:
- Reset: all FIFOs empty; FSM IDLE. All of the following are 0: En_in, Clr_in, b_in, done, busy, err, ready. a_in reads 0 (all FIFOs empty).
- Clr_in, En_in, b_in and done are registered. a_in[i] is the combinational show-ahead head of FIFO i, or 0 when that FIFO is empty.
- Loading:
  - Loads are accepted only in IDLE.
  - A write is dropped and sets err if the target FIFO is full, if wr_sel > N, or if busy=1.
- FSM states: IDLE, CLR, STREAM, DRAIN, DONE.
  - IDLE -> CLR: on the edge where start=1 and ready=1.
  - start in IDLE with ready=0: ignored, err unchanged.
  - start while busy: ignored.
  - CLR (1 cycle): Clr_in=1, En_in=0.
  - STREAM (exactly N cycles): En_in=1, Clr_in=0. Each cycle pops B and registers it into b_in, so b_in carries B[0..N-1] in write order.
  - DRAIN: En_in=0, b_in holds last value. Exits on the first cycle en_out==0, checked only after at least one DRAIN cycle has elapsed. With the N-stage array this takes N+1 cycles after STREAM ends.
  - DONE (1 cycle): done=1, then return to IDLE.
- Timing: start accepted at edge t gives Clr_in high in cycle t+1, En_in high in cycles t+2..t+N+1, and done high in cycle t+2N+3 (N=8: cycle t+19).
- A-lane pop: FIFO i pops on every cycle en_out[i]=1, regardless of FSM state.
  - Pop on an empty FIFO: no state change, a_in[i]=0, err set.
- Simultaneous push and pop on the same FIFO cannot occur (loads are blocked while busy). If it does occur, the pop wins and the write is dropped with err set.
- FIFO pointers wrap modulo N. Full/empty is tracked by a count register of width $clog2(N+1).
- Reset asserted mid-operation: FSM returns to IDLE and FIFOs empty immediately. En_in and Clr_in drop asynchronously. Downstream array contents are undefined until the next Clr.
- No arithmetic in this block. Widths pass through unchanged.

Decomposition:
- Shared package mac8_pkg:
  - DATA_WIDTH and N defaults.
  - typedef feeder_state_t enum {IDLE, CLR, STREAM, DRAIN, DONE}.
  - typedef operand_t logic [DATA_WIDTH-1:0].
- One sub-module: sync_fifo_sa (show-ahead synchronous FIFO, params WIDTH/DEPTH; ports push, pop, din, dout, full, empty, count).
  - Instantiated N+1 times: N A-lane FIFOs plus one B FIFO.
- The feeder FSM stays in mac8_feeder.

Test Plan:
- Basic run, with the MAC8 array instantiated downstream: load every A lane with 1..8 and B with 1..8, then start. Required: Clr_in 1 cycle, then En_in 8 cycles; every c_out = 204; done exactly 19 cycles after start; err=0.
- Per-lane alignment: lane i loaded with constant i+1, B = 2,2,...,2. Required: c_out[i] = 16·(i+1) for i=0..7; a_in[i] changes only on cycles where en_out[i]=1.
- Overflow and illegal select: 9 writes to lane 3, then one write with wr_sel=9. Required: 9th write and illegal write dropped; err=1; lane 3 count=8; ready stays 0 until the remaining FIFOs are filled.
- Start gating: start with B FIFO holding 7 entries -> no Clr_in, busy=0. Write the 8th entry, start again -> run proceeds normally. Pulse start again mid-STREAM -> no effect.
- Back-to-back runs: reload during IDLE immediately after done, A=all 3, B=all 1. Required: c_out = 24 (Clr clears the previous 204); FIFOs empty after done.
- Reset mid-STREAM: assert rst_n=0 during the 4th En_in cycle. Required: En_in, Clr_in, busy, ready and err all 0 immediately; FIFO counts 0; a fresh load-and-start yields 204 again.
